// File: rtl/alu_seq_pkg.sv
// alu_seq_pkg: op codes, flag bit positions and FSM states shared by the
// sequential ALU and its multiplier core.
package alu_seq_pkg;
    localparam logic [2:0] OP_ADD = 3'b000;
    localparam logic [2:0] OP_SUB = 3'b001;
    localparam logic [2:0] OP_AND = 3'b010;
    localparam logic [2:0] OP_OR  = 3'b011;
    localparam logic [2:0] OP_XOR = 3'b100;
    localparam logic [2:0] OP_NOT = 3'b101;
    localparam logic [2:0] OP_MUL = 3'b110;
    localparam logic [2:0] OP_ADC = 3'b111;

    localparam int FLAG_Z = 0;
    localparam int FLAG_N = 1;
    localparam int FLAG_V = 2;
    localparam int FLAG_C = 3;

    typedef enum logic {S_IDLE, S_BUSY} state_t;
endpackage

// File: rtl/alu_seq_mul.sv
// alu_seq_mul: iterative shift-add multiplier; bit 0 is folded into the start
// load so the remaining WIDTH-1 bits finish in WIDTH-1 steps.
module alu_seq_mul #(
    parameter int WIDTH = 16
) (
    input  logic                 i_clk,
    input  logic                 i_rst_n,
    input  logic                 i_start,
    input  logic                 i_step,
    input  logic [WIDTH-1:0]     i_a,
    input  logic [WIDTH-1:0]     i_b,
    output logic                 o_done,
    output logic [2*WIDTH-1:0]   o_product
);
    localparam int CW = $clog2(WIDTH);

    logic [2*WIDTH-1:0] r_acc;
    logic [2*WIDTH-1:0] r_mcand;
    logic [WIDTH-1:0]   r_mplier;
    logic [CW-1:0]      r_count;

    // Product as it stands after the step being taken this cycle.
    assign o_product = r_acc + (r_mplier[0] ? r_mcand : '0);
    assign o_done    = i_step && (r_count == CW'(WIDTH - 2));

    always_ff @(posedge i_clk) begin
        if (!i_rst_n) begin
            r_acc    <= '0;
            r_mcand  <= '0;
            r_mplier <= '0;
            r_count  <= '0;
        end else if (i_start) begin
            r_acc    <= i_b[0] ? {{WIDTH{1'b0}}, i_a} : '0;
            r_mcand  <= {{(WIDTH-1){1'b0}}, i_a, 1'b0};
            r_mplier <= i_b >> 1;
            r_count  <= '0;
        end else if (i_step) begin
            r_acc    <= o_product;
            r_mcand  <= r_mcand << 1;
            r_mplier <= r_mplier >> 1;
            r_count  <= r_count + 1'b1;
        end
    end
endmodule

// File: rtl/alu_seq.sv
// alu_seq: registered ALU with stored C/V/N/Z status, carry-consuming ADC and
// an iterative multiplier behind a valid/ready input handshake.
module alu_seq
    import alu_seq_pkg::*;
#(
    parameter int WIDTH = 16
) (
    input  logic             i_clk,
    input  logic             i_rst_n,
    input  logic             i_in_valid,
    output logic             o_in_ready,
    input  logic [WIDTH-1:0] i_a,
    input  logic [WIDTH-1:0] i_b,
    input  logic [2:0]       i_op,
    output logic             o_out_valid,
    output logic [WIDTH-1:0] o_y,
    output logic             o_c,
    output logic             o_v,
    output logic             o_n,
    output logic             o_z
);
    localparam int M = WIDTH - 1;

    state_t             r_state;
    logic [WIDTH-1:0]   r_y;
    logic [3:0]         r_flags;
    logic               r_out_valid;

    logic               w_accept;
    logic               w_is_mul;
    logic               w_sub;
    logic               w_arith;
    logic [WIDTH-1:0]   w_bop;
    logic [WIDTH:0]     w_sum;
    logic [WIDTH-1:0]   w_res;
    logic [3:0]         w_flags;
    logic [3:0]         w_mflags;
    logic               w_mul_done;
    logic [2*WIDTH-1:0] w_product;

    assign o_in_ready  = (r_state == S_IDLE);
    assign w_accept    = i_in_valid && o_in_ready;
    assign w_is_mul    = (i_op == OP_MUL);
    assign w_sub       = (i_op == OP_SUB);
    assign w_arith     = (i_op == OP_ADD) || w_sub || (i_op == OP_ADC);
    // One adder serves ADD/SUB/ADC; only the B inversion and carry-in differ.
    assign w_bop       = w_sub ? ~i_b : i_b;
    assign w_sum       = {1'b0, i_a} + {1'b0, w_bop}
                       + (WIDTH+1)'(w_sub || ((i_op == OP_ADC) && r_flags[FLAG_C]));
    assign w_res       = (i_op == OP_AND) ? (i_a & i_b) :
                         (i_op == OP_OR)  ? (i_a | i_b) :
                         (i_op == OP_XOR) ? (i_a ^ i_b) :
                         (i_op == OP_NOT) ? ~i_a : w_sum[M:0];

    always_comb begin
        w_flags         = r_flags;
        w_flags[FLAG_C] = w_arith ? w_sum[WIDTH] : r_flags[FLAG_C];
        w_flags[FLAG_V] = w_arith ? ((i_a[M] == w_bop[M]) && (w_res[M] != i_a[M])) : r_flags[FLAG_V];
        w_flags[FLAG_N] = w_res[M];
        w_flags[FLAG_Z] = (w_res == '0);
        w_mflags         = '0;
        w_mflags[FLAG_C] = |w_product[2*WIDTH-1:WIDTH];
        w_mflags[FLAG_N] = w_product[M];
        w_mflags[FLAG_Z] = (w_product[M:0] == '0);
    end

    alu_seq_mul #(.WIDTH(WIDTH)) u_mul (
        .i_clk     (i_clk),
        .i_rst_n   (i_rst_n),
        .i_start   (w_accept && w_is_mul),
        .i_step    (r_state == S_BUSY),
        .i_a       (i_a),
        .i_b       (i_b),
        .o_done    (w_mul_done),
        .o_product (w_product)
    );

    always_ff @(posedge i_clk) begin
        if (!i_rst_n) begin
            r_state     <= S_IDLE;
            r_y         <= '0;
            r_flags     <= '0;
            r_out_valid <= 1'b0;
        end else begin
            r_out_valid <= 1'b0;
            if (w_accept && !w_is_mul) begin
                r_y         <= w_res;
                r_flags     <= w_flags;
                r_out_valid <= 1'b1;
            end else if (w_accept) begin
                r_state <= S_BUSY;
            end else if (w_mul_done) begin
                r_y         <= w_product[M:0];
                r_flags     <= w_mflags;
                r_out_valid <= 1'b1;
                r_state     <= S_IDLE;
            end
        end
    end

    assign o_out_valid = r_out_valid;
    assign o_y         = r_y;
    assign o_c         = r_flags[FLAG_C];
    assign o_v         = r_flags[FLAG_V];
    assign o_n         = r_flags[FLAG_N];
    assign o_z         = r_flags[FLAG_Z];
endmodule

// File: tb/tb_alu_seq.sv
// tb_alu_seq: scenario tasks drive the ALU and compare against an arithmetic
// model of the result and status flags.
module tb_alu_seq;
    localparam int W = 16;

    logic         clk = 1'b0;
    logic         rst_n = 1'b0;
    logic         in_valid = 1'b0;
    logic [W-1:0] a = '0;
    logic [W-1:0] b = '0;
    logic [2:0]   op = '0;
    logic         in_ready, out_valid, c, v, n, z;
    logic [W-1:0] y;

    int vectors = 0;
    int miscompares = 0;
    logic [W-1:0] m_y = '0;
    logic m_c = 1'b0, m_v = 1'b0, m_n = 1'b0, m_z = 1'b0;

    alu_seq #(.WIDTH(W)) dut (
        .i_clk(clk), .i_rst_n(rst_n), .i_in_valid(in_valid), .o_in_ready(in_ready),
        .i_a(a), .i_b(b), .i_op(op), .o_out_valid(out_valid), .o_y(y),
        .o_c(c), .o_v(v), .o_n(n), .o_z(z)
    );

    always #5 clk = ~clk;

    function automatic void model(input logic [2:0] o, input logic [15:0] xa, input logic [15:0] xb);
        int ua = int'(xa);
        int ub = int'(xb);
        int sa = $signed(xa);
        int sb = $signed(xb);
        int r = 0;
        int sr = 0;
        longint p;
        if (o == 3'd0 || o == 3'd1 || o == 3'd7) begin
            if (o == 3'd0) begin r = ua + ub; sr = sa + sb; end
            else if (o == 3'd1) begin r = ua + (65535 - ub) + 1; sr = sa - sb; end
            else begin r = ua + ub + int'(m_c); sr = sa + sb + int'(m_c); end
            m_y = 16'(r);
            m_c = (r > 65535);
            m_v = (sr > 32767) || (sr < -32768);
        end else if (o == 3'd6) begin
            p = longint'(ua) * longint'(ub);
            m_y = 16'(p);
            m_c = (p > 65535);
            m_v = 1'b0;
        end else begin
            m_y = (o == 3'd2) ? (xa & xb) : (o == 3'd3) ? (xa | xb) : (o == 3'd4) ? (xa ^ xb) : ~xa;
        end
        m_n = m_y[15];
        m_z = (m_y == 16'd0);
    endfunction

    task automatic issue(input logic [2:0] o, input logic [15:0] xa, input logic [15:0] xb);
        @(negedge clk);
        op = o; a = xa; b = xb; in_valid = 1'b1;
        @(posedge clk);
        model(o, xa, xb);
        #1 in_valid = 1'b0;
    endtask

    task automatic test_reset;
        rst_n = 1'b0;
        repeat (3) @(posedge clk);
        #1 rst_n = 1'b1;
        vectors++;
        if ({out_valid, in_ready, y, c, v, n, z} !== {1'b0, 1'b1, 16'h0, 4'b0}) begin
            miscompares++;
            $display("FAIL reset: got valid=%b ready=%b y=%h cvnz=%b%b%b%b, want 0 1 0000 0000",
                     out_valid, in_ready, y, c, v, n, z);
        end
    endtask

    task automatic test_add_overflow;
        issue(3'd0, 16'h7FFF, 16'h0001);
        vectors++;
        if ({out_valid, y, c, v, n, z} !== {1'b1, 16'h8000, 4'b0110}) begin
            miscompares++;
            $display("FAIL add_ovf: got valid=%b y=%h cvnz=%b%b%b%b, want 1 8000 0110", out_valid, y, c, v, n, z);
        end
        @(posedge clk);
        #1 vectors++;
        if (out_valid !== 1'b0) begin
            miscompares++;
            $display("FAIL add_pulse: got valid=%b, want 0", out_valid);
        end
    endtask

    task automatic test_sub_xor;
        issue(3'd1, 16'h0005, 16'h0005);
        vectors++;
        if ({out_valid, y, c, v, n, z} !== {1'b1, 16'h0000, 4'b1001}) begin
            miscompares++;
            $display("FAIL sub_eq: got valid=%b y=%h cvnz=%b%b%b%b, want 1 0000 1001", out_valid, y, c, v, n, z);
        end
        issue(3'd4, 16'h00F0, 16'h000F);
        vectors++;
        if ({out_valid, y, c, v, n, z} !== {1'b1, 16'h00FF, 4'b1000}) begin
            miscompares++;
            $display("FAIL xor_hold: got valid=%b y=%h cvnz=%b%b%b%b, want 1 00ff 1000", out_valid, y, c, v, n, z);
        end
    endtask

    task automatic test_adc_chain;
        issue(3'd0, 16'hFFFF, 16'h0001);
        vectors++;
        if ({y, c, z} !== {16'h0000, 1'b1, 1'b1}) begin
            miscompares++;
            $display("FAIL add_carry: got y=%h c=%b z=%b, want 0000 1 1", y, c, z);
        end
        issue(3'd7, 16'h0001, 16'h0001);
        vectors++;
        if ({out_valid, y, c} !== {1'b1, 16'h0003, 1'b0}) begin
            miscompares++;
            $display("FAIL adc: got valid=%b y=%h c=%b, want 1 0003 0", out_valid, y, c);
        end
        issue(3'd5, 16'h00FF, 16'h1234);
        vectors++;
        if ({y, c, n} !== {16'hFF00, 1'b0, 1'b1}) begin
            miscompares++;
            $display("FAIL not: got y=%h c=%b n=%b, want ff00 0 1", y, c, n);
        end
    endtask

    task automatic test_mul(input logic [15:0] xa, input logic [15:0] xb);
        int busy = 0;
        bit done = 0;
        @(negedge clk);
        op = 3'd6; a = xa; b = xb; in_valid = 1'b1;
        @(posedge clk);
        model(3'd6, xa, xb);
        for (int i = 0; i < 40 && !done; i++) begin
            #1;
            if (out_valid) done = 1;
            else begin
                busy++;
                vectors++;
                if (in_ready !== 1'b0) begin
                    miscompares++;
                    $display("FAIL mul_ready: got ready=%b in busy cycle %0d, want 0", in_ready, busy);
                end
                a = 16'($urandom);
                b = 16'($urandom);
                @(posedge clk);
            end
        end
        in_valid = 1'b0;
        vectors++;
        if (!done || busy != W - 1) begin
            miscompares++;
            $display("FAIL mul_latency: got done=%0d busy=%0d, want 1 %0d", done, busy, W - 1);
        end
        vectors++;
        if ({in_ready, y, c, v, n, z} !== {1'b1, m_y, m_c, m_v, m_n, m_z}) begin
            miscompares++;
            $display("FAIL mul %h*%h: got ready=%b y=%h cvnz=%b%b%b%b, want 1 %h %b%b%b%b",
                     xa, xb, in_ready, y, c, v, n, z, m_y, m_c, m_v, m_n, m_z);
        end
        @(posedge clk);
        #1 vectors++;
        if (out_valid !== 1'b0) begin
            miscompares++;
            $display("FAIL mul_extra: got valid=%b after result, want 0", out_valid);
        end
    endtask

    task automatic test_back_to_back;
        int r;
        for (int i = 0; i < 200; i++) begin
            r = $urandom_range(0, 6);
            if (r == 6) r = 7;
            @(negedge clk);
            vectors++;
            if (in_ready !== 1'b1) begin
                miscompares++;
                $display("FAIL b2b_ready: got %b at op %0d, want 1", in_ready, i);
            end
            op = 3'(r); a = 16'($urandom); b = 16'($urandom); in_valid = 1'b1;
            @(posedge clk);
            model(op, a, b);
            #1 vectors++;
            if ({out_valid, y, c, v, n, z} !== {1'b1, m_y, m_c, m_v, m_n, m_z}) begin
                miscompares++;
                $display("FAIL b2b op=%0d a=%h b=%h: got valid=%b y=%h cvnz=%b%b%b%b, want 1 %h %b%b%b%b",
                         op, a, b, out_valid, y, c, v, n, z, m_y, m_c, m_v, m_n, m_z);
            end
        end
        in_valid = 1'b0;
    endtask

    task automatic test_reset_mid_mul;
        issue(3'd6, 16'h1234, 16'h0077);
        for (int i = 0; i < 4; i++) begin
            @(posedge clk);
            #1 vectors++;
            if (out_valid !== 1'b0) begin
                miscompares++;
                $display("FAIL abort_early: got valid=%b, want 0", out_valid);
            end
        end
        rst_n = 1'b0;
        @(posedge clk);
        #1 rst_n = 1'b1;
        m_y = '0; m_c = 0; m_v = 0; m_n = 0; m_z = 0;
        vectors++;
        if ({out_valid, in_ready, y, c, v, n, z} !== {1'b0, 1'b1, 16'h0, 4'b0}) begin
            miscompares++;
            $display("FAIL abort: got valid=%b ready=%b y=%h cvnz=%b%b%b%b, want 0 1 0000 0000",
                     out_valid, in_ready, y, c, v, n, z);
        end
        issue(3'd0, 16'h0002, 16'h0003);
        vectors++;
        if ({out_valid, y} !== {1'b1, 16'h0005}) begin
            miscompares++;
            $display("FAIL post_reset_add: got valid=%b y=%h, want 1 0005", out_valid, y);
        end
    endtask

    initial begin
        test_reset;
        test_add_overflow;
        test_sub_xor;
        test_adc_chain;
        test_mul(16'h0100, 16'h0100);
        test_mul(16'h0003, 16'h0005);
        for (int i = 0; i < 8; i++) test_mul(16'($urandom), 16'($urandom));
        test_back_to_back;
        test_reset_mid_mul;
        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end
endmodule
